// File: rtl/fractal_sync_2x1_ctrl.sv
// Two-child node of the fractal synchronization tree. It resolves barriers at its own level,
// forwards higher-level barriers to the parent, and answers bad or mismatched requests with an error.
module fractal_sync_2x1_ctrl #(
  parameter int unsigned LVL_WIDTH = 2,
  parameter int unsigned NODE_LVL  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 slv0_sync_i,
  input  logic [LVL_WIDTH-1:0] slv0_level_i,
  output logic                 slv0_wake_o,
  output logic                 slv0_error_o,
  input  logic                 slv0_ack_i,
  input  logic                 slv1_sync_i,
  input  logic [LVL_WIDTH-1:0] slv1_level_i,
  output logic                 slv1_wake_o,
  output logic                 slv1_error_o,
  input  logic                 slv1_ack_i,
  output logic                 mst_sync_o,
  output logic [LVL_WIDTH-1:0] mst_level_o,
  input  logic                 mst_wake_i,
  input  logic                 mst_error_i,
  output logic                 mst_ack_o
);

  typedef enum logic [1:0] {IDLE, UP, RESP} state_t;

  localparam logic [LVL_WIDTH-1:0] NODE_LVL_C = LVL_WIDTH'(NODE_LVL);

  state_t               state_q, state_d;
  logic [1:0]           pending_q, pending_d;
  logic [LVL_WIDTH-1:0] level_q [2];
  logic [LVL_WIDTH-1:0] level_d [2];
  logic [1:0]           wake_q, wake_d;
  logic [1:0]           err_q, err_d;
  logic                 mst_sync_q, mst_sync_d;
  logic                 mst_ack_q, mst_ack_d;
  logic [LVL_WIDTH-1:0] mst_level_q, mst_level_d;

  logic [1:0]           sync_in, ack_in, bad, clr;
  logic [LVL_WIDTH-1:0] lvl_in [2];
  logic                 both, same, local_lvl, up_resp, resp_done;

  assign sync_in   = {slv1_sync_i, slv0_sync_i};
  assign ack_in    = {slv1_ack_i, slv0_ack_i};
  assign lvl_in[0] = slv0_level_i;
  assign lvl_in[1] = slv1_level_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_child
      // A level below this node can never be resolved by it or any ancestor.
      assign bad[gi] = pending_q[gi] && (level_q[gi] < NODE_LVL_C);
      assign clr[gi] = ack_in[gi] && (wake_q[gi] || err_q[gi]);
    end
  endgenerate

  assign both      = &pending_q;
  assign same      = (level_q[0] == level_q[1]);
  assign local_lvl = (level_q[0] == NODE_LVL_C);
  assign up_resp   = mst_wake_i || mst_error_i;
  assign resp_done = (((wake_q | err_q) & ~clr) == 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      level_q[0]  <= '0;
      level_q[1]  <= '0;
      wake_q      <= '0;
      err_q       <= '0;
      mst_sync_q  <= 1'b0;
      mst_ack_q   <= 1'b0;
      mst_level_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      level_q[0]  <= level_d[0];
      level_q[1]  <= level_d[1];
      wake_q      <= wake_d;
      err_q       <= err_d;
      mst_sync_q  <= mst_sync_d;
      mst_ack_q   <= mst_ack_d;
      mst_level_q <= mst_level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if ((|bad) || (both && (!same || local_lvl))) state_d = RESP;
        else if (both)                                state_d = UP;
      end
      UP:      if (up_resp)   state_d = RESP;
      RESP:    if (resp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d   = pending_q;
    level_d[0]  = level_q[0];
    level_d[1]  = level_q[1];
    wake_d      = wake_q & ~clr;
    err_d       = err_q & ~clr;
    mst_sync_d  = 1'b0;
    mst_ack_d   = 1'b0;
    mst_level_d = mst_level_q;
    for (int n = 0; n < 2; n++) begin
      if (clr[n]) pending_d[n] = 1'b0;
      // Capture only into a free slot; duplicates while pending are dropped.
      if (!pending_q[n] && sync_in[n]) begin
        pending_d[n] = 1'b1;
        level_d[n]   = lvl_in[n];
      end
    end
    case (state_q)
      IDLE: begin
        if (|bad)                    err_d  = bad;
        else if (both && !same)      err_d  = 2'b11;
        else if (both && local_lvl)  wake_d = 2'b11;
        else if (both) begin
          mst_sync_d  = 1'b1;
          mst_level_d = level_q[0];
        end
      end
      UP: begin
        if (up_resp) begin
          mst_ack_d = 1'b1;
          if (mst_error_i) err_d  = 2'b11;
          else             wake_d = 2'b11;
        end
      end
      default: ;
    endcase
  end

  assign slv0_wake_o  = wake_q[0];
  assign slv1_wake_o  = wake_q[1];
  assign slv0_error_o = err_q[0];
  assign slv1_error_o = err_q[1];
  assign mst_sync_o   = mst_sync_q;
  assign mst_ack_o    = mst_ack_q;
  assign mst_level_o  = mst_level_q;

endmodule

// File: doc/fractal_sync_2x1_ctrl.md
Name: fractal_sync_2x1_ctrl

Overview:
Binary node controller for the fractal synchronization tree. It accepts barrier requests from two child ports and resolves them locally when the requested level equals this node's level. Requests for higher levels are aggregated and forwarded to the parent port. Invalid or mismatched requests are answered with error. Instances are stacked in a tree to build the full synchronization network.

Parameters:
LVL_WIDTH, 2, width of level field on all ports
NODE_LVL, 1, tree level resolved by this node (1..2^LVL_WIDTH-1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
slv0_sync_i  in  1  child0 sync request pulse
slv0_level_i  in  LVL_WIDTH  child0 requested level, valid with sync
slv0_wake_o  out  1  child0 barrier granted, held until ack
slv0_error_o  out  1  child0 error, held until ack
slv0_ack_i  in  1  child0 acknowledge pulse
slv1_sync_i, slv1_level_i, slv1_wake_o, slv1_error_o, slv1_ack_i: same as child0, for child1
mst_sync_o  out  1  forwarded request pulse to parent
mst_level_o  out  LVL_WIDTH  forwarded level, stable from pulse until parent response
mst_wake_i  in  1  parent grant, level-high until mst_ack_o
mst_error_i  in  1  parent error, level-high until mst_ack_o
mst_ack_o  out  1  one-cycle acknowledge to parent

Behaviour:
- Single clock clk_i. rst_i synchronous, active-high. Reset clears all registers: pending[1:0]=0, levels=0, state=IDLE. All outputs 0 the cycle after reset is sampled. In-flight requests are dropped.
- Capture: slvN_sync_i sampled at an edge with pending[N]=0 sets pending[N] and stores slvN_level_i. A sync while pending[N]=1 is ignored; the stored level is unchanged.
- FSM states: IDLE, UP, RESP. Response flags wake_q[1:0] and err_q[1:0] are registered and drive slvN_wake_o and slvN_error_o directly.
- IDLE evaluates the registered pending and level values each cycle. Priority is top-down:
  1. Any pending child with level < NODE_LVL (including 0): set err_q for that child only, go to RESP.
  2. Both pending, levels differ: set err_q for both, go to RESP.
  3. Both pending, level == NODE_LVL: set wake_q for both, go to RESP.
  4. Both pending, level > NODE_LVL: mst_sync_o=1 for one cycle, mst_level_o=level, go to UP.
  5. Otherwise stay in IDLE.
- Latency: child sync at cycle t gives pending at t+1 and wake, error or mst_sync_o at t+2.
- UP: mst_level_o held. On mst_wake_i or mst_error_i at cycle k:
  - mst_ack_o=1 at k+1 for one cycle.
  - Both children get wake_q (or err_q if mst_error_i was set) at k+1.
  - Go to RESP. If wake and error arrive together, error wins.
- RESP: flags are held. slvN_ack_i with a flag set clears wake_q[N], err_q[N] and pending[N] at the next edge. When all flags are clear, return to IDLE. A child whose pending bit has cleared may issue a new sync during RESP; it is captured and evaluated once the FSM reaches IDLE.
- Ignored inputs:
  - ack with no flag set.
  - Parent wake or error outside UP; no mst_ack_o is generated.
- wake and error are never asserted together on one port.

Test Plan:
NODE_LVL=1, LVL_WIDTH=2 for all scenarios.
- Local barrier: both sync with level 1 at cycle 0 -> both wake=1 at cycle 2. ack0 at cycle 4 -> wake0=0 at cycle 5. ack1 at cycle 6 -> wake1=0 at cycle 7, IDLE.
- Forwarding: both sync with level 2 at cycle 0 -> mst_sync_o pulse at cycle 2 with mst_level_o=2. mst_wake_i at cycle 5 -> mst_ack_o pulse and both wake=1 at cycle 6. Parent error variant -> both error=1 at cycle 6.
- Invalid level: child0 sync with level 0 at cycle 0 -> error0=1 at cycle 2, wake1/error1=0, child1 pending unaffected. After ack0, child1 level 1 plus child0 level 1 -> normal wake.
- Mismatch: child0 level 1, child1 level 2 at cycle 0 -> error0=error1=1 at cycle 2, mst_sync_o stays 0.
- Staggered and duplicate: child0 level 1 at cycle 0; a duplicate child0 sync with level 3 at cycle 5 is ignored; child1 level 1 at cycle 10 -> both wake=1 at cycle 12.
- Reset mid-UP: rst_i at cycle 3 while in UP -> all outputs 0 at cycle 4. mst_wake_i at cycle 6 -> no mst_ack_o, no child wake.
